// File: rtl/board_status_checker_pkg.sv
// Shared constants and types for the 4x4 board status checker.
// DIAG_CHECK_EN adds the two diagonal lines to the scan (10 lines instead of 8).
package board_status_checker_pkg;

  localparam int BOARD_ROWS = 4;
  localparam int BOARD_COLS = 4;
  localparam int CELLS      = BOARD_ROWS * BOARD_COLS;
  localparam int CELL_IDX_W = 4;
  localparam int LINE_CELLS = 4;
  localparam int LINE_IDX_W = 4;

`ifdef DIAG_CHECK_EN
  localparam int LINE_COUNT = 10;
`else
  localparam int LINE_COUNT = 8;
`endif

  localparam logic [LINE_IDX_W-1:0] LAST_LINE   = LINE_IDX_W'(LINE_COUNT - 1);
  localparam logic [LINE_IDX_W-1:0] NO_WIN_LINE = 4'hF;

  typedef enum logic [1:0] {
    ST_PLAYING = 2'b00,
    ST_P1_WIN  = 2'b01,
    ST_P2_WIN  = 2'b10,
    ST_DRAW    = 2'b11
  } game_status_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SCAN   = 2'b01,
    S_REPORT = 2'b10
  } fsm_state_t;

endpackage

// File: rtl/board_status_checker_win_line_table.sv
// Maps a line index to its four cell indices (cell = row*4 + col).
// Lines 0-3 rows, 4-7 columns, 8 diagonal, 9 anti-diagonal.
module win_line_table
  import board_status_checker_pkg::*;
(
  input  logic [LINE_IDX_W-1:0]                  line,
  output logic [LINE_CELLS-1:0][CELL_IDX_W-1:0]  cells
);

  always_comb begin
    cells = '0;
    for (int i = 0; i < LINE_CELLS; i++) begin
      case (line)
        4'd0, 4'd1, 4'd2, 4'd3: cells[i] = {line[1:0], 2'(i)};
        4'd4, 4'd5, 4'd6, 4'd7: cells[i] = {2'(i), line[1:0]};
        4'd8:                   cells[i] = {2'(i), 2'(i)};
        4'd9:                   cells[i] = {2'(i), 2'(3 - i)};
        default:                cells[i] = '0;
      endcase
    end
  end

endmodule

// File: rtl/board_status_checker.sv
// Scans a snapshot of the board one line per cycle and reports the game status.
// Define DIAG_CHECK_EN to include the diagonal lines in the scan.
module board_status_checker
  import board_status_checker_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CELLS-1:0]      in_gameboard,
  input  logic [CELLS-1:0]      in_players_cells,
  output logic [1:0]            out_game_status,
  output logic                  busy,
  output logic                  done,
  output logic [LINE_IDX_W-1:0] win_line
);

  fsm_state_t state, next_state;

  logic [LINE_IDX_W-1:0]                 line_cnt;
  logic [CELLS-1:0]                      board_snap;
  logic [CELLS-1:0]                      player_snap;
  logic                                  found;
  logic                                  winner;
  logic [LINE_IDX_W-1:0]                 found_line;
  logic [LINE_CELLS-1:0][CELL_IDX_W-1:0] cells;
  logic                                  line_won;
  logic                                  line_player;
  logic                                  accept;
  logic                                  scanning;
  logic                                  reporting;
  logic [1:0]                            report_status;

  win_line_table u_win_line_table (
    .line  (line_cnt),
    .cells (cells)
  );

  // A finished game is terminal: new requests are ignored until reset.
  assign accept = (state == S_IDLE) && start && (out_game_status == ST_PLAYING);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_SCAN;
      S_SCAN:   if (line_cnt == LAST_LINE) next_state = S_REPORT;
      S_REPORT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    scanning  = (state == S_SCAN);
    reporting = (state == S_REPORT);
  end

  // Line evaluation works only on the snapshot, so mid-scan input changes are invisible.
  always_comb begin
    line_player = player_snap[cells[0]];
    line_won    = 1'b1;
    for (int i = 0; i < LINE_CELLS; i++) begin
      if (!board_snap[cells[i]] || (player_snap[cells[i]] != line_player)) begin
        line_won = 1'b0;
      end
    end
  end

  always_comb begin
    if (found) begin
      report_status = winner ? ST_P2_WIN : ST_P1_WIN;
    end else if (board_snap == {CELLS{1'b1}}) begin
      report_status = ST_DRAW;
    end else begin
      report_status = ST_PLAYING;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_cnt        <= '0;
      found           <= 1'b0;
      done            <= 1'b0;
      out_game_status <= ST_PLAYING;
      win_line        <= NO_WIN_LINE;
    end else begin
      done <= 1'b0;
      if (accept) begin
        line_cnt <= '0;
        found    <= 1'b0;
      end else if (scanning) begin
        line_cnt <= line_cnt + 1'b1;
        if (line_won) begin
          found <= 1'b1;
        end
      end
      if (reporting) begin
        done            <= 1'b1;
        out_game_status <= report_status;
        win_line        <= found ? found_line : NO_WIN_LINE;
      end
    end
  end

  // Only the first (lowest-index) winning line is kept.
  always_ff @(posedge clk) begin
    if (accept) begin
      board_snap  <= in_gameboard;
      player_snap <= in_players_cells;
    end
    if (scanning && line_won && !found) begin
      found_line <= line_cnt;
      winner     <= line_player;
    end
  end

endmodule

// File: tb/tb_board_status_checker.sv
// Directed bench for board_status_checker; expected values are hand-computed.
// Latency and diagonal expectations follow DIAG_CHECK_EN.
module tb_board_status_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gameboard = 16'h0000;
  logic [15:0] players = 16'h0000;
  logic [1:0]  game_status;
  logic        busy;
  logic        done;
  logic [3:0]  win_line;

  int vectors = 0;
  int miscompares = 0;

`ifdef DIAG_CHECK_EN
  localparam int  LAT  = 11;
  localparam bit  DIAG = 1'b1;
`else
  localparam int  LAT  = 9;
  localparam bit  DIAG = 1'b0;
`endif

  board_status_checker dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_gameboard     (gameboard),
    .in_players_cells (players),
    .out_game_status  (game_status),
    .busy             (busy),
    .done             (done),
    .win_line         (win_line)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Pulse start, scramble the inputs during the scan, then measure latency and result.
  task automatic evaluate(input string tag, input logic [15:0] b, input logic [15:0] p,
                          input logic [1:0] es, input logic [3:0] el, input int elat);
    int lat;
    bit seen;
    @(negedge clk);
    gameboard = b;
    players   = p;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    gameboard = ~b;
    players   = ~p;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      seen = (done === 1'b1);
    end
    if (!seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(lat), 32'(elat));
      chk({tag, "_status"}, 32'(game_status), 32'(es));
      chk({tag, "_win_line"}, 32'(win_line), 32'(el));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dones;
    int busies;

    apply_reset();
    @(negedge clk);
    chk("reset_status", 32'(game_status), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_win_line", 32'(win_line), 32'hF);

    evaluate("empty", 16'h0000, 16'h0000, 2'b00, 4'hF, LAT);
    evaluate("partial", 16'h0007, 16'h0000, 2'b00, 4'hF, LAT);
    if (DIAG) evaluate("diag", 16'h8421, 16'h0000, 2'b01, 4'h8, LAT);
    else      evaluate("diag", 16'h8421, 16'h0000, 2'b00, 4'hF, LAT);

    apply_reset();
    evaluate("row0_p1", 16'h000F, 16'h0000, 2'b01, 4'h0, LAT);

    // Terminal status: a new start is ignored entirely.
    @(negedge clk);
    gameboard = 16'h0000;
    players   = 16'h0000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("terminal_busy", 32'(busy), 32'd0);
    dones  = 0;
    busies = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
    end
    chk("terminal_dones", 32'(dones), 32'd0);
    chk("terminal_busies", 32'(busies), 32'd0);
    chk("terminal_status", 32'(game_status), 32'h1);

    apply_reset();
    evaluate("col2_p2", 16'h4444, 16'h4444, 2'b10, 4'h6, LAT);

    apply_reset();
    evaluate("draw", 16'hFFFF, 16'h3C3C, 2'b11, 4'hF, LAT);

    apply_reset();
    evaluate("lowest_line", 16'hFF00, 16'hFF00, 2'b10, 4'h2, LAT);

    apply_reset();
    evaluate("full_p1", 16'hFFFF, 16'h0000, 2'b01, 4'h0, LAT);

    // Reset two cycles into a scan aborts it without a done pulse.
    apply_reset();
    @(negedge clk);
    gameboard = 16'h000F;
    players   = 16'h0000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_status", 32'(game_status), 32'h0);
    chk("abort_win_line", 32'(win_line), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // A second start while busy must not produce a second result.
    @(negedge clk);
    gameboard = 16'h000F;
    players   = 16'h0000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) begin
        @(negedge clk);
        gameboard = 16'h4444;
        players   = 16'h4444;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) dones++;
    end
    chk("busy_start_dones", 32'(dones), 32'd1);
    chk("busy_start_status", 32'(game_status), 32'h1);
    chk("busy_start_win_line", 32'(win_line), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
